// File: rtl/vc_wrr_sched.sv
// Weighted round-robin scheduler: four VC head FIFOs onto two output FIFOs.
// Optional per-class grant and stall counters are enabled with `define VC_SCHED_STATS_EN.
module vc_wrr_sched #(
  parameter int DATA_W     = 5,
  parameter int WEIGHT_VC0 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] VC0_p0,
  input  logic [DATA_W-1:0] VC1_p0,
  input  logic [DATA_W-1:0] VC0_p1,
  input  logic [DATA_W-1:0] VC1_p1,
  input  logic              emptyVC0_p0,
  input  logic              emptyVC1_p0,
  input  logic              emptyVC0_p1,
  input  logic              emptyVC1_p1,
  input  logic              almost_full_out0,
  input  logic              almost_full_out1,
  output logic              popVC0_p0,
  output logic              popVC1_p0,
  output logic              popVC0_p1,
  output logic              popVC1_p1,
  output logic              push_out0,
  output logic              push_out1,
  output logic [DATA_W-1:0] dataOut0,
  output logic [DATA_W-1:0] dataOut1,
  output logic [1:0]        state
`ifdef VC_SCHED_STATS_EN
  ,
  output logic [7:0]        grant_cnt_vc0,
  output logic [7:0]        grant_cnt_vc1,
  output logic [7:0]        stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VC0  = 2'd1,
    S_VC1  = 2'd2
  } state_t;

  localparam logic [3:0] WEIGHT = 4'(WEIGHT_VC0);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state_q;
  logic [3:0]        vc0_cnt;
  logic              rr_vc0;
  logic              rr_vc1;

  // Source index: bit 0 = class (0 = VC0, 1 = VC1), bit 1 = port.
  logic [DATA_W-1:0] head [4];
  logic [3:0]        empty_v;
  logic [3:0]        elig;
  logic              any_vc0;
  logic              any_vc1;
  logic              gnt_vc0;
  logic              gnt_vc1;
  logic              gnt_any;
  logic              port_vc0;
  logic              port_vc1;
  logic              gnt_port;
  logic [1:0]        gnt_idx;
  logic [DATA_W-1:0] gnt_word;
  logic              gnt_dst;
  logic [3:0]        pop;

  assign head[0] = VC0_p0;
  assign head[1] = VC1_p0;
  assign head[2] = VC0_p1;
  assign head[3] = VC1_p1;
  assign empty_v = {emptyVC1_p1, emptyVC0_p1, emptyVC1_p0, emptyVC0_p0};

  // A blocked head only masks its own source, so other sources still get through.
  always_comb begin
    elig = 4'b0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = !empty_v[i] && !reset &&
                !(head[i][DATA_W-1] ? almost_full_out1 : almost_full_out0);
    end
  end

  assign any_vc0 = elig[0] | elig[2];
  assign any_vc1 = elig[1] | elig[3];

  always_comb begin
    gnt_vc0 = 1'b0;
    gnt_vc1 = 1'b0;
    case (state_q)
      S_VC0: begin
        // Once the weight is spent VC1 goes next; VC0 continues only if VC1 is idle.
        if (any_vc0 && ((vc0_cnt < WEIGHT) || !any_vc1)) gnt_vc0 = 1'b1;
        else if (any_vc1)                                 gnt_vc1 = 1'b1;
      end
      default: begin
        if (any_vc0)      gnt_vc0 = 1'b1;
        else if (any_vc1) gnt_vc1 = 1'b1;
      end
    endcase
  end

  assign port_vc0 = (elig[0] && elig[2]) ? rr_vc0 : elig[2];
  assign port_vc1 = (elig[1] && elig[3]) ? rr_vc1 : elig[3];
  assign gnt_any  = gnt_vc0 | gnt_vc1;
  assign gnt_port = gnt_vc1 ? port_vc1 : port_vc0;
  assign gnt_idx  = {gnt_port, gnt_vc1};
  assign gnt_word = head[gnt_idx];
  assign gnt_dst  = gnt_word[DATA_W-1];
  assign pop      = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;

  assign popVC0_p0 = pop[0];
  assign popVC1_p0 = pop[1];
  assign popVC0_p1 = pop[2];
  assign popVC1_p1 = pop[3];
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      vc0_cnt   <= 4'd0;
      rr_vc0    <= 1'b0;
      rr_vc1    <= 1'b0;
      push_out0 <= 1'b0;
      push_out1 <= 1'b0;
      dataOut0  <= '0;
      dataOut1  <= '0;
    end else begin
      push_out0 <= gnt_any && !gnt_dst;
      push_out1 <= gnt_any && gnt_dst;
      if (gnt_any && !gnt_dst) dataOut0 <= gnt_word;
      if (gnt_any && gnt_dst)  dataOut1 <= gnt_word;
      if (gnt_vc0) rr_vc0 <= ~port_vc0;
      if (gnt_vc1) rr_vc1 <= ~port_vc1;
      if (gnt_vc1) begin
        state_q <= S_VC1;
        vc0_cnt <= 4'd0;
      end else if (gnt_vc0) begin
        state_q <= S_VC0;
        if (state_q != S_VC0)    vc0_cnt <= 4'd1;
        else if (vc0_cnt < WEIGHT) vc0_cnt <= vc0_cnt + 4'd1;
      end else begin
        state_q <= S_IDLE;
      end
    end
  end

`ifdef VC_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt_vc0 <= 8'd0;
      grant_cnt_vc1 <= 8'd0;
      stall_cycles  <= 8'd0;
    end else begin
      if (gnt_vc0) grant_cnt_vc0 <= sat_inc8(grant_cnt_vc0);
      if (gnt_vc1) grant_cnt_vc1 <= sat_inc8(grant_cnt_vc1);
      if (!(&empty_v) && !(|elig)) stall_cycles <= sat_inc8(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_vc_wrr_sched.sv
// Scoreboard bench for vc_wrr_sched: expected pops checked in the grant cycle,
// expected pushes queued and checked one clock later.
module tb_vc_wrr_sched;
  localparam int DATA_W     = 5;
  localparam int WEIGHT_VC0 = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] VC0_p0, VC1_p0, VC0_p1, VC1_p1;
  logic              emptyVC0_p0, emptyVC1_p0, emptyVC0_p1, emptyVC1_p1;
  logic              almost_full_out0, almost_full_out1;
  logic              popVC0_p0, popVC1_p0, popVC0_p1, popVC1_p1;
  logic              push_out0, push_out1;
  logic [DATA_W-1:0] dataOut0, dataOut1;
  logic [1:0]        state;

  typedef struct packed {
    logic              vld;
    logic              rst;
    logic [DATA_W-1:0] word;
  } exp_t;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] exp_d0   = '0;
  logic [DATA_W-1:0] exp_d1   = '0;

  always #5 clk = ~clk;

  vc_wrr_sched #(.DATA_W(DATA_W), .WEIGHT_VC0(WEIGHT_VC0)) dut (
    .clk(clk), .reset(reset),
    .VC0_p0(VC0_p0), .VC1_p0(VC1_p0), .VC0_p1(VC0_p1), .VC1_p1(VC1_p1),
    .emptyVC0_p0(emptyVC0_p0), .emptyVC1_p0(emptyVC1_p0),
    .emptyVC0_p1(emptyVC0_p1), .emptyVC1_p1(emptyVC1_p1),
    .almost_full_out0(almost_full_out0), .almost_full_out1(almost_full_out1),
    .popVC0_p0(popVC0_p0), .popVC1_p0(popVC1_p0),
    .popVC0_p1(popVC0_p1), .popVC1_p1(popVC1_p1),
    .push_out0(push_out0), .push_out1(push_out1),
    .dataOut0(dataOut0), .dataOut1(dataOut1),
    .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop order {VC1_p1, VC0_p1, VC1_p0, VC0_p0}.
  task automatic step(input string tag, input logic [3:0] exp_pop);
    exp_t e;
    #1;
    check({tag, "_pop"}, {28'd0, popVC1_p1, popVC0_p1, popVC1_p0, popVC0_p0}, {28'd0, exp_pop});
    e.vld = (exp_pop != 4'b0000);
    e.rst = reset;
    case (exp_pop)
      4'b0001: e.word = VC0_p0;
      4'b0010: e.word = VC1_p0;
      4'b0100: e.word = VC0_p1;
      4'b1000: e.word = VC1_p1;
      default: e.word = '0;
    endcase
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.rst) begin
      exp_d0 = '0;
      exp_d1 = '0;
    end else if (e.vld) begin
      if (e.word[DATA_W-1]) exp_d1 = e.word;
      else                  exp_d0 = e.word;
    end
    check({tag, "_push0"}, {31'd0, push_out0}, {31'd0, e.vld && !e.word[DATA_W-1]});
    check({tag, "_push1"}, {31'd0, push_out1}, {31'd0, e.vld && e.word[DATA_W-1]});
    check({tag, "_data0"}, {27'd0, dataOut0}, {27'd0, exp_d0});
    check({tag, "_data1"}, {27'd0, dataOut1}, {27'd0, exp_d1});
  endtask

  task automatic all_empty();
    emptyVC0_p0 = 1'b1; emptyVC1_p0 = 1'b1;
    emptyVC0_p1 = 1'b1; emptyVC1_p1 = 1'b1;
  endtask

  logic [3:0] wrr_order [8];

  initial begin
    wrr_order = '{4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0100, 4'b1000};
    reset = 1'b1;
    VC0_p0 = '0; VC1_p0 = '0; VC0_p1 = '0; VC1_p1 = '0;
    almost_full_out0 = 1'b0; almost_full_out1 = 1'b0;
    all_empty();

    // Reset then idle.
    step("rst", 4'b0000);
    step("rst", 4'b0000);
    check("rst_state", {30'd0, state}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("idle", 4'b0000);
      check("idle_state", {30'd0, state}, 32'd0);
    end

    // Single source routed to out0.
    VC0_p0 = 5'b00001; emptyVC0_p0 = 1'b0;
    for (int i = 0; i < 3; i++) step("single", 4'b0001);
    check("single_state", {30'd0, state}, 32'd1);
    all_empty();
    step("single_drain", 4'b0000);

    // Destination routing to out1.
    VC0_p1 = 5'b11000; emptyVC0_p1 = 1'b0;
    step("route", 4'b0100);
    all_empty();
    step("route_drain", 4'b0000);

    // Weighted order with all four sources backlogged toward out0.
    reset = 1'b1;
    step("wrr_rst", 4'b0000);
    reset = 1'b0;
    VC0_p0 = 5'b00001; VC1_p0 = 5'b00010; VC0_p1 = 5'b00011; VC1_p1 = 5'b00100;
    emptyVC0_p0 = 1'b0; emptyVC1_p0 = 1'b0; emptyVC0_p1 = 1'b0; emptyVC1_p1 = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) step("wrr", wrr_order[i]);
    all_empty();
    step("wrr_drain", 4'b0000);

    // Backpressure: out1 full blocks only the VC0_p0 head.
    VC0_p0 = 5'b10010; VC1_p0 = 5'b00010;
    emptyVC0_p0 = 1'b0; emptyVC1_p0 = 1'b0;
    almost_full_out1 = 1'b1;
    for (int i = 0; i < 3; i++) step("bp_hold", 4'b0010);
    check("bp_state", {30'd0, state}, 32'd2);
    almost_full_out1 = 1'b0;
    step("bp_release", 4'b0001);
    // Full rising in the push cycle must not drop the already granted word.
    almost_full_out1 = 1'b1;
    step("bp_late_full", 4'b0010);
    almost_full_out1 = 1'b0;
    all_empty();
    step("bp_drain", 4'b0000);

    // Reset in a grant cycle suppresses the grant.
    VC0_p0 = 5'b00001; emptyVC0_p0 = 1'b0;
    step("mid", 4'b0001);
    step("mid", 4'b0001);
    reset = 1'b1;
    step("mid_rst", 4'b0000);
    check("mid_rst_state", {30'd0, state}, 32'd0);
    reset = 1'b0;
    VC0_p1 = 5'b00011; emptyVC0_p1 = 1'b0;
    step("post_rst_p0", 4'b0001);
    step("post_rst_p1", 4'b0100);
    all_empty();
    step("post_drain", 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
